// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage
// ----------------------------------------------------------------------------
// Front-end PC generator and instruction queue. Drives the fetch PC into the
// instruction cache, captures the returned word together with its PC and the
// predicted next PC into a small FIFO, and presents the FIFO head to decode
// over a valid/ready handshake. Execute can redirect fetch at any time, which
// flushes everything that was fetched down the old path.
//
// Parameters
//   RESET_PC  fetch PC loaded on reset
//   QDEPTH    instruction queue entries (power of 2, >= 2)
//
// Ports
//   CLK             in   1   clock, all state on rising edge
//   reset           in   1   asynchronous active-low reset (0 = in reset)
//   fe_pc           out  64  fetch PC, drives the instruction cache
//   icache_r        in   1   icache word valid for fe_pc this cycle
//   icache_instr    in   32  instruction word from icache
//   redirect_valid  in   1   execute redirect request
//   redirect_pc     in   64  redirect target (low two bits forced to zero)
//   de_valid        out  1   queue head valid to decode
//   de_ready        in   1   decode accepts the head
//   de_instruction  out  32  head instruction word
//   de_pc           out  64  head PC
//   de_npc          out  64  head predicted next PC
//
// Build option
//   FE_JAL_PREDICT_EN  when defined, JAL instructions predict their own
//                      target as the next PC instead of fe_pc + 4.
// ============================================================================
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          QDEPTH   = 2
) (
    input  logic        CLK,
    input  logic        reset,
    output logic [63:0] fe_pc,
    input  logic        icache_r,
    input  logic [31:0] icache_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        de_valid,
    input  logic        de_ready,
    output logic [31:0] de_instruction,
    output logic [63:0] de_pc,
    output logic [63:0] de_npc
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    typedef enum logic {
        BOOT,
        FETCH
    } state_e;

    state_e          state_q, state_d;
    logic            fetchEn;
    logic [63:0]     fePc_q, fePc_d;
    logic [PW-1:0]   wrPtr_q, wrPtr_d;
    logic [PW-1:0]   rdPtr_q, rdPtr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [63:0]     npc;
    logic            full;
    logic            push;
    logic            pop;

    logic [63:0]     pcMem    [QDEPTH];
    logic [31:0]     instrMem [QDEPTH];
    logic [63:0]     npcMem   [QDEPTH];

    // State register: BOOT gives the icache one cycle to preload.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: BOOT always moves on, FETCH is terminal until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   state_d = FETCH;
            default: state_d = BOOT;
        endcase
    end

    // Output decode of the FSM: pushing is only allowed once out of BOOT.
    always_comb begin
        fetchEn = 1'b0;
        case (state_q)
            FETCH:   fetchEn = 1'b1;
            default: fetchEn = 1'b0;
        endcase
    end

    // Next-PC prediction for the word currently returned by the icache.
`ifdef FE_JAL_PREDICT_EN
    logic [20:0] jalOffset;
    assign jalOffset = {icache_instr[31], icache_instr[19:12], icache_instr[20],
                        icache_instr[30:21], 1'b0};

    always_comb begin
        npc = fePc_q + 64'd4;
        if (icache_instr[6:0] == 7'h6F) begin
            npc = fePc_q + {{43{jalOffset[20]}}, jalOffset};
        end
    end
`else
    assign npc = fePc_q + 64'd4;
`endif

    // A redirect suppresses both queue ports for the cycle; full blocks a push
    // even when a pop frees a slot in the same cycle.
    assign full = (count_q == CW'(QDEPTH));
    assign push = fetchEn && icache_r && !full && !redirect_valid;
    assign pop  = de_valid && de_ready && !redirect_valid;

    // Next-state for the fetch PC and queue bookkeeping. Redirect wins over
    // everything and empties the queue so no wrong-path word reaches decode.
    always_comb begin
        fePc_d  = fePc_q;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (redirect_valid) begin
            fePc_d  = redirect_pc & ~64'h3;
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) begin
                fePc_d  = npc;
                wrPtr_d = wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Fetch PC and queue control registers.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            fePc_q  <= RESET_PC;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            fePc_q  <= fePc_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Queue storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            pcMem[wrPtr_q]    <= fePc_q;
            instrMem[wrPtr_q] <= icache_instr;
            npcMem[wrPtr_q]   <= npc;
        end
    end

    assign fe_pc          = fePc_q;
    assign de_valid       = (count_q != '0);
    assign de_instruction = de_valid ? instrMem[rdPtr_q] : 32'h0;
    assign de_pc          = de_valid ? pcMem[rdPtr_q]    : 64'h0;
    assign de_npc         = de_valid ? npcMem[rdPtr_q]   : 64'h0;

endmodule
